// File: rtl/wakeup_arbiter.sv
// rtl/wakeup_arbiter.sv - merges mapped irq edges and a sw wake FIFO into one registered wakeup stream
module wakeup_arbiter #(
  parameter int NUM_IRQ    = 8,
  parameter int TASK_BITS  = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_IRQ-1:0]            irq,
  input  logic                          map_we,
  input  logic [$clog2(NUM_IRQ)-1:0]    map_irq,
  input  logic [TASK_BITS-1:0]          map_task,
  input  logic                          map_en,
  input  logic                          sw_valid,
  input  logic [TASK_BITS-1:0]          sw_id,
  output logic                          sw_ready,
  output logic                          wakeup_valid,
  output logic [TASK_BITS-1:0]          wakeup_id,
  output logic                          irq_overrun,
  output logic [NUM_IRQ-1:0]            pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int IW = $clog2(NUM_IRQ);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [NUM_IRQ-1:0]   irq_prev_q, irq_prev_d;
  logic [NUM_IRQ-1:0]   pending_q, pending_d;
  logic [NUM_IRQ-1:0]   map_en_q, map_en_d;
  logic [TASK_BITS-1:0] map_task_q [NUM_IRQ];
  logic [TASK_BITS-1:0] map_task_d [NUM_IRQ];
  logic [TASK_BITS-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [TASK_BITS-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 last_src_q, last_src_d;
  logic                 wakeup_valid_q, wakeup_valid_d;
  logic [TASK_BITS-1:0] wakeup_id_q, wakeup_id_d;
  logic                 irq_overrun_q, irq_overrun_d;

  logic                 irq_hit;
  logic [IW-1:0]        irq_sel;
  int                   scan_idx;
  logic                 sw_avail;
  logic                 grant_irq, grant_sw;
  logic                 push;
  logic [NUM_IRQ-1:0]   rise, grant_mask, disable_clear;

  assign sw_ready     = (count_q < CW'(FIFO_DEPTH));
  assign wakeup_valid = wakeup_valid_q;
  assign wakeup_id    = wakeup_id_q;
  assign irq_overrun  = irq_overrun_q;
  assign pending      = pending_q;
  assign fifo_count   = count_q;

  // Round-robin scan: first pending index at or after rr_ptr, wrapping to 0.
  always_comb begin
    irq_hit  = 1'b0;
    irq_sel  = '0;
    scan_idx = 0;
    for (int off = 0; off < NUM_IRQ; off++) begin
      scan_idx = int'(rr_ptr_q) + off;
      if (scan_idx >= NUM_IRQ) scan_idx = scan_idx - NUM_IRQ;
      if (!irq_hit && pending_q[IW'(scan_idx)]) begin
        irq_hit = 1'b1;
        irq_sel = IW'(scan_idx);
      end
    end
  end

  // When both sources contend, alternate away from whichever was served last.
  always_comb begin
    sw_avail  = (count_q != '0);
    grant_irq = 1'b0;
    grant_sw  = 1'b0;
    if (en) begin
      if (irq_hit && sw_avail) begin
        grant_sw  = !last_src_q;
        grant_irq = last_src_q;
      end else begin
        grant_irq = irq_hit;
        grant_sw  = sw_avail;
      end
    end
  end

  always_comb begin
    rise          = irq & ~irq_prev_q & map_en_q;
    grant_mask    = grant_irq ? (NUM_IRQ'(1) << irq_sel) : '0;
    disable_clear = (map_we && !map_en) ? (NUM_IRQ'(1) << map_irq) : '0;
    irq_prev_d    = irq;
    pending_d     = (pending_q & ~grant_mask & ~disable_clear) | rise;
    irq_overrun_d = |(rise & pending_q & ~grant_mask);

    map_en_d   = map_en_q;
    map_task_d = map_task_q;
    if (map_we) begin
      map_en_d[map_irq]   = map_en;
      map_task_d[map_irq] = map_task;
    end
  end

  // sw_ready is based on the registered count, so a full FIFO refuses even while popping.
  always_comb begin
    push       = sw_valid && sw_ready;
    fifo_mem_d = fifo_mem_q;
    if (push) fifo_mem_d[wr_ptr_q] = sw_id;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(grant_sw);
    count_d  = count_q + CW'(push) - CW'(grant_sw);
  end

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    last_src_d     = last_src_q;
    wakeup_valid_d = grant_irq || grant_sw;
    wakeup_id_d    = wakeup_id_q;
    if (grant_irq) begin
      rr_ptr_d    = (irq_sel == IW'(NUM_IRQ - 1)) ? '0 : irq_sel + IW'(1);
      last_src_d  = 1'b0;
      wakeup_id_d = map_task_q[irq_sel];
    end else if (grant_sw) begin
      last_src_d  = 1'b1;
      wakeup_id_d = fifo_mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev_q     <= '0;
      pending_q      <= '0;
      map_en_q       <= '0;
      for (int i = 0; i < NUM_IRQ; i++) map_task_q[i] <= TASK_BITS'(i);
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      rr_ptr_q       <= '0;
      last_src_q     <= 1'b0;
      wakeup_valid_q <= 1'b0;
      wakeup_id_q    <= '0;
      irq_overrun_q  <= 1'b0;
    end else begin
      irq_prev_q     <= irq_prev_d;
      pending_q      <= pending_d;
      map_en_q       <= map_en_d;
      map_task_q     <= map_task_d;
      fifo_mem_q     <= fifo_mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      rr_ptr_q       <= rr_ptr_d;
      last_src_q     <= last_src_d;
      wakeup_valid_q <= wakeup_valid_d;
      wakeup_id_q    <= wakeup_id_d;
      irq_overrun_q  <= irq_overrun_d;
    end
  end
endmodule

// File: tb/tb_wakeup_arbiter.sv
// tb/tb_wakeup_arbiter.sv - directed and randomized bench for wakeup_arbiter against a queue-based model
module tb_wakeup_arbiter;
  localparam int N  = 8;
  localparam int TB = 3;
  localparam int D  = 4;

  logic          clk;
  logic          rst;
  logic          en;
  logic [N-1:0]  irq;
  logic          map_we;
  logic [2:0]    map_irq;
  logic [TB-1:0] map_task;
  logic          map_en;
  logic          sw_valid;
  logic [TB-1:0] sw_id;
  logic          sw_ready;
  logic          wakeup_valid;
  logic [TB-1:0] wakeup_id;
  logic          irq_overrun;
  logic [N-1:0]  pending;
  logic [2:0]    fifo_count;

  wakeup_arbiter #(.NUM_IRQ(N), .TASK_BITS(TB), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .en(en), .irq(irq),
    .map_we(map_we), .map_irq(map_irq), .map_task(map_task), .map_en(map_en),
    .sw_valid(sw_valid), .sw_id(sw_id), .sw_ready(sw_ready),
    .wakeup_valid(wakeup_valid), .wakeup_id(wakeup_id), .irq_overrun(irq_overrun),
    .pending(pending), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays and a queue, updated once per clock.
  int m_prev [N];
  int m_pend [N];
  int m_men  [N];
  int m_task [N];
  int m_fifo [$];
  int m_rr, m_last, m_wv, m_wid, m_ovr;
  int gi, g_irq, g_sw, ovr, can_push, rise_i;
  int np [N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_prev[i] = 0; m_pend[i] = 0; m_men[i] = 0; m_task[i] = i % (1 << TB);
      end
      m_fifo.delete();
      m_rr = 0; m_last = 0; m_wv = 0; m_wid = 0; m_ovr = 0;
    end else begin
      gi = -1;
      for (int k = 0; k < N; k++)
        if (gi < 0 && m_pend[(m_rr + k) % N] != 0) gi = (m_rr + k) % N;
      g_irq = 0; g_sw = 0;
      if (en) begin
        if (gi >= 0 && m_fifo.size() > 0) begin
          if (m_last == 0) g_sw = 1; else g_irq = 1;
        end else if (gi >= 0) g_irq = 1;
        else if (m_fifo.size() > 0) g_sw = 1;
      end
      ovr = 0;
      for (int i = 0; i < N; i++) begin
        np[i] = m_pend[i];
        rise_i = (irq[i] && m_prev[i] == 0 && m_men[i] != 0) ? 1 : 0;
        if (g_irq != 0 && gi == i) np[i] = 0;
        if (map_we && !map_en && int'(map_irq) == i) np[i] = 0;
        if (rise_i != 0) begin
          if (m_pend[i] != 0 && !(g_irq != 0 && gi == i)) ovr = 1;
          np[i] = 1;
        end
      end
      can_push = (m_fifo.size() < D) ? 1 : 0;
      if (g_irq != 0) begin
        m_wv = 1; m_wid = m_task[gi]; m_rr = (gi + 1) % N; m_last = 0;
      end else if (g_sw != 0) begin
        m_wv = 1; m_wid = m_fifo.pop_front(); m_last = 1;
      end else m_wv = 0;
      if (sw_valid && can_push != 0) m_fifo.push_back(int'(sw_id));
      if (map_we) begin
        m_men[map_irq]  = map_en ? 1 : 0;
        m_task[map_irq] = int'(map_task);
      end
      m_ovr = ovr;
      for (int i = 0; i < N; i++) begin
        m_pend[i] = np[i];
        m_prev[i] = irq[i] ? 1 : 0;
      end
    end
  end

  function automatic logic [31:0] model_pending();
    logic [31:0] v = 0;
    for (int i = 0; i < N; i++) if (m_pend[i] != 0) v[i] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("cmp_wakeup_valid", 32'(wakeup_valid), m_wv);
      chk("cmp_wakeup_id", 32'(wakeup_id), m_wid);
      chk("cmp_irq_overrun", 32'(irq_overrun), m_ovr);
      chk("cmp_pending", 32'(pending), model_pending());
      chk("cmp_fifo_count", 32'(fifo_count), m_fifo.size());
      chk("cmp_sw_ready", 32'(sw_ready), (m_fifo.size() < D) ? 1 : 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic map_wr(input int idx, input int tsk, input bit ena);
    map_we = 1'b1; map_irq = 3'(idx); map_task = TB'(tsk); map_en = ena;
    cyc();
    map_we = 1'b0;
  endtask

  task automatic expect_wake(input string name, input int id);
    cyc();
    chk({name, "_valid"}, 32'(wakeup_valid), 1);
    chk({name, "_id"}, 32'(wakeup_id), id);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; irq = '0; map_we = 1'b0; map_irq = '0; map_task = '0;
    map_en = 1'b0; sw_valid = 1'b0; sw_id = '0;
    repeat (3) cyc();
    chk("rst_wakeup_valid", 32'(wakeup_valid), 0);
    chk("rst_wakeup_id", 32'(wakeup_id), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_sw_ready", 32'(sw_ready), 1);
    chk("rst_irq_overrun", 32'(irq_overrun), 0);
    rst = 1'b0;
    en = 1'b1;
    for (int i = 0; i < N; i++) map_wr(i, (i == 2) ? 5 : i, 1'b1);

    // irq2 mapped to task 5: pending after one edge, wakeup after the next
    irq = 8'h04;
    cyc();
    chk("t1_pending", 32'(pending), 32'h04);
    irq = 8'h00;
    expect_wake("t1_wake", 5);
    chk("t1_pending_clr", 32'(pending), 0);

    // bring rr_ptr to 0 via irq7, then 1,4,6 together
    irq = 8'h80; cyc(); irq = 8'h00;
    expect_wake("t2_pre7", 7);
    irq = 8'h52; cyc(); irq = 8'h00;
    expect_wake("t2_a", 1);
    expect_wake("t2_b", 4);
    expect_wake("t2_c", 6);
    irq = 8'h81; cyc(); irq = 8'h00;
    expect_wake("t2_rr7", 7);
    expect_wake("t2_rr0", 0);

    // last_src=1 via an sw grant, then irq3 vs FIFO {6,2}
    sw_valid = 1'b1; sw_id = 3'd7; cyc(); sw_valid = 1'b0;
    expect_wake("t3_pre_sw", 7);
    en = 1'b0;
    sw_valid = 1'b1; sw_id = 3'd6; cyc();
    sw_id = 3'd2; cyc(); sw_valid = 1'b0;
    irq = 8'h08; cyc(); irq = 8'h00;
    chk("t3_count", 32'(fifo_count), 2);
    en = 1'b1;
    expect_wake("t3_irq3", 3);
    expect_wake("t3_sw6", 6);
    expect_wake("t3_sw2", 2);

    // overrun while en=0 coalesces into one wakeup
    en = 1'b0;
    irq = 8'h01; cyc();
    chk("t4_pending", 32'(pending), 32'h01);
    irq = 8'h00; cyc();
    irq = 8'h01; cyc();
    chk("t4_overrun", 32'(irq_overrun), 1);
    chk("t4_no_wake", 32'(wakeup_valid), 0);
    irq = 8'h00; cyc();
    chk("t4_overrun_clr", 32'(irq_overrun), 0);
    en = 1'b1;
    expect_wake("t4_wake", 0);
    cyc();
    chk("t4_single", 32'(wakeup_valid), 0);

    // fill FIFO with en=0, fifth push refused, then drain in order
    en = 1'b0;
    sw_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sw_id = TB'(2 * i + 1);
      cyc();
    end
    chk("t5_full_count", 32'(fifo_count), 4);
    chk("t5_not_ready", 32'(sw_ready), 0);
    sw_id = 3'd2; cyc(); sw_valid = 1'b0;
    chk("t5_refused", 32'(fifo_count), 4);
    en = 1'b1;
    expect_wake("t5_d0", 1);
    expect_wake("t5_d1", 3);
    expect_wake("t5_d2", 5);
    expect_wake("t5_d3", 7);
    cyc();
    chk("t5_empty", 32'(fifo_count), 0);

    // disabling map[5] drops its pending bit and ignores later edges
    en = 1'b0;
    irq = 8'h20; cyc(); irq = 8'h00;
    chk("t6_pending", 32'(pending), 32'h20);
    map_wr(5, 5, 1'b0);
    chk("t6_cleared", 32'(pending), 0);
    en = 1'b1; cyc();
    chk("t6_no_wake", 32'(wakeup_valid), 0);
    irq = 8'h20; cyc(); irq = 8'h00;
    chk("t6_ignored", 32'(pending), 0);
    cyc();
    chk("t6_no_wake2", 32'(wakeup_valid), 0);

    // randomized traffic, with one mid-run reset
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
      end
      en       = ($urandom_range(0, 3) != 0);
      irq      = irq ^ (N'($urandom) & N'($urandom) & N'($urandom));
      sw_valid = ($urandom_range(0, 2) == 0);
      sw_id    = TB'($urandom);
      map_we   = ($urandom_range(0, 7) == 0);
      map_irq  = 3'($urandom);
      map_task = TB'($urandom);
      map_en   = ($urandom_range(0, 3) != 0);
      cyc();
    end
    map_we = 1'b0; sw_valid = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
